// File: rtl/vga_sync_decoder_if.sv
// Sync/RGB stream into vga_sync_decoder and the decoded position/status coming back out.
interface vga_sync_decoder_if;
   logic        i_hsync;
   logic        i_vsync;
   logic [3:0]  i_red;
   logic [3:0]  i_green;
   logic [3:0]  i_blue;
   logic        o_pix_valid;
   logic [9:0]  o_col;
   logic [9:0]  o_row;
   logic [3:0]  o_red;
   logic [3:0]  o_green;
   logic [3:0]  o_blue;
   logic        o_frame_start;
   logic        o_locked;
   logic        o_err;
   logic [7:0]  o_err_cnt;
   logic [15:0] o_checksum;
   logic        o_cks_valid;

   // Video source / checker side
   modport master (
      output i_hsync, i_vsync, i_red, i_green, i_blue,
      input  o_pix_valid, o_col, o_row, o_red, o_green, o_blue,
             o_frame_start, o_locked, o_err, o_err_cnt, o_checksum, o_cks_valid
   );

   // Decoder side
   modport slave (
      input  i_hsync, i_vsync, i_red, i_green, i_blue,
      output o_pix_valid, o_col, o_row, o_red, o_green, o_blue,
             o_frame_start, o_locked, o_err, o_err_cnt, o_checksum, o_cks_valid
   );
endinterface

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: receive-side VGA timing recovery. Rebuilds col/row from the sync
// edges, checks them against the expected line/frame timing, locks after LOCK_FRAMES
// clean vsync edges and reports timing violations.
// Optional frame checksum enabled by macro VGA_SYNC_DECODER_CHECKSUM_EN.
module vga_sync_decoder #(
   parameter int unsigned H_VIS           = 640,
   parameter int unsigned H_FP            = 16,
   parameter int unsigned H_SYNC          = 96,
   parameter int unsigned H_BP            = 48,
   parameter int unsigned V_VIS           = 480,
   parameter int unsigned V_FP            = 10,
   parameter int unsigned V_SYNC          = 2,
   parameter int unsigned V_BP            = 33,
   parameter int unsigned SYNC_ACTIVE_LOW = 1,
   parameter int unsigned LOCK_FRAMES     = 2
) (
   input logic              clk,
   input logic              rst,
   vga_sync_decoder_if.slave io_vga
);

   localparam int unsigned CW    = 10;
   localparam int unsigned EW    = 8;
   localparam int unsigned VCW   = 4;
   localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0]  C_H_LAST  = CW'(H_TOT - 1);
   localparam logic [CW-1:0]  C_V_LAST  = CW'(V_TOT - 1);
   localparam logic [CW-1:0]  C_HS_RISE = CW'(H_VIS + H_FP);
   localparam logic [CW-1:0]  C_HS_FALL = CW'(H_VIS + H_FP + H_SYNC);
   localparam logic [CW-1:0]  C_VS_ROW  = CW'(V_VIS + V_FP);
   localparam logic [CW-1:0]  C_H_VIS   = CW'(H_VIS);
   localparam logic [CW-1:0]  C_V_VIS   = CW'(V_VIS);
   localparam logic [VCW-1:0] C_LOCK_N  = VCW'(LOCK_FRAMES);
   localparam logic [EW-1:0]  C_ERR_MAX = '1;
   localparam logic           ACT_LVL   = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

   localparam logic [1:0] S_SEARCH = 2'd0;
   localparam logic [1:0] S_H_OK   = 2'd1;
   localparam logic [1:0] S_VERIFY = 2'd2;
   localparam logic [1:0] S_LOCKED = 2'd3;

   logic           w_hs_act;
   logic           w_vs_act;
   logic           r_hs_act_d;
   logic           r_vs_act_d;
   logic           w_hs_rise;
   logic           w_hs_fall;
   logic           w_vs_rise;

   logic [CW-1:0]  r_col;
   logic [CW-1:0]  r_row;
   logic [CW-1:0]  w_pred_col;
   logic [CW-1:0]  w_pred_row;
   logic [CW-1:0]  w_row_inc;
   logic [CW-1:0]  w_col_nxt;
   logic [CW-1:0]  w_row_nxt;
   logic           w_col_wrap;
   logic           w_hs_viol;
   logic           w_vs_viol;

   logic [1:0]     r_state;
   logic [1:0]     w_state_nxt;
   logic [VCW-1:0] r_vcnt;
   logic [VCW-1:0] w_vcnt_nxt;
   logic           w_viol;

   logic           w_lock_nxt;
   logic           w_pv_nxt;
   logic           w_fs_nxt;

   logic           r_pix_valid;
   logic [3:0]     r_red;
   logic [3:0]     r_green;
   logic [3:0]     r_blue;
   logic           r_frame_start;
   logic           r_locked;
   logic           r_err;
   logic [EW-1:0]  r_err_cnt;

   // Sync levels normalised to "asserted" and edge detection against registered history
   assign w_hs_act  = (io_vga.i_hsync == ACT_LVL);
   assign w_vs_act  = (io_vga.i_vsync == ACT_LVL);
   assign w_hs_rise = w_hs_act & ~r_hs_act_d;
   assign w_hs_fall = ~w_hs_act & r_hs_act_d;
   assign w_vs_rise = w_vs_act & ~r_vs_act_d;

   // Free-running position prediction, sync-edge realignment and timing checks
   always_comb begin
      w_col_wrap = 1'b0;
      w_pred_col = '0;
      w_row_inc  = '0;
      w_pred_row = r_row;
      w_col_nxt  = '0;
      w_row_nxt  = r_row;
      w_hs_viol  = 1'b0;
      w_vs_viol  = 1'b0;

      w_col_wrap = (r_col == C_H_LAST);
      w_pred_col = w_col_wrap ? '0 : r_col + CW'(1);
      w_row_inc  = (r_row == C_V_LAST) ? '0 : r_row + CW'(1);
      w_pred_row = w_col_wrap ? w_row_inc : r_row;

      w_col_nxt = w_hs_rise ? C_HS_RISE : w_pred_col;
      if (w_vs_rise) begin
         w_row_nxt = C_VS_ROW;
      end else if (w_col_wrap && !w_hs_rise) begin
         w_row_nxt = w_row_inc;
      end

      // An edge where none is expected, or no edge where one is, both count
      w_hs_viol = (w_hs_rise != (w_pred_col == C_HS_RISE)) |
                  (w_hs_fall != (w_pred_col == C_HS_FALL));
      w_vs_viol = (w_vs_rise != ((w_pred_row == C_VS_ROW) && (w_pred_col == '0)));
   end

   // Lock FSM next-state: acquire hsync, then vsync, then LOCK_FRAMES clean vsync edges
   always_comb begin
      w_state_nxt = r_state;
      w_vcnt_nxt  = r_vcnt;
      w_viol      = 1'b0;
      case (r_state)
         S_SEARCH: begin
            if (w_hs_rise) begin
               w_state_nxt = S_H_OK;
            end
         end
         S_H_OK: begin
            if (w_hs_viol) begin
               w_viol      = 1'b1;
               w_state_nxt = S_SEARCH;
            end else if (w_vs_rise) begin
               w_state_nxt = S_VERIFY;
               w_vcnt_nxt  = '0;
            end
         end
         S_VERIFY: begin
            if (w_hs_viol || w_vs_viol) begin
               w_viol      = 1'b1;
               w_state_nxt = S_SEARCH;
            end else if (w_vs_rise) begin
               if ((r_vcnt + VCW'(1)) == C_LOCK_N) begin
                  w_state_nxt = S_LOCKED;
               end else begin
                  w_vcnt_nxt = r_vcnt + VCW'(1);
               end
            end
         end
         S_LOCKED: begin
            if (w_hs_viol || w_vs_viol) begin
               w_viol      = 1'b1;
               w_state_nxt = S_SEARCH;
            end
         end
         default: begin
            w_state_nxt = S_SEARCH;
         end
      endcase
   end

   // Status derived from the next position so it lines up with o_col/o_row
   assign w_lock_nxt = (w_state_nxt == S_LOCKED);
   assign w_pv_nxt   = w_lock_nxt && (w_col_nxt < C_H_VIS) && (w_row_nxt < C_V_VIS);
   assign w_fs_nxt   = w_lock_nxt && (w_col_nxt == '0) && (w_row_nxt == '0);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_SEARCH;
         r_vcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_vcnt  <= w_vcnt_nxt;
      end
   end

   // Sync history and recovered position
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hs_act_d <= 1'b0;
         r_vs_act_d <= 1'b0;
         r_col      <= '0;
         r_row      <= '0;
      end else begin
         r_hs_act_d <= w_hs_act;
         r_vs_act_d <= w_vs_act;
         r_col      <= w_col_nxt;
         r_row      <= w_row_nxt;
      end
   end

   // Registered status, aligned RGB and violation reporting
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pix_valid   <= 1'b0;
         r_red         <= '0;
         r_green       <= '0;
         r_blue        <= '0;
         r_frame_start <= 1'b0;
         r_locked      <= 1'b0;
         r_err         <= 1'b0;
         r_err_cnt     <= '0;
      end else begin
         r_pix_valid   <= w_pv_nxt;
         r_red         <= w_pv_nxt ? io_vga.i_red   : 4'd0;
         r_green       <= w_pv_nxt ? io_vga.i_green : 4'd0;
         r_blue        <= w_pv_nxt ? io_vga.i_blue  : 4'd0;
         r_frame_start <= w_fs_nxt;
         r_locked      <= w_lock_nxt;
         r_err         <= w_viol;
         if (w_viol && (r_err_cnt != C_ERR_MAX)) begin
            r_err_cnt <= r_err_cnt + EW'(1);
         end
      end
   end

   assign io_vga.o_pix_valid   = r_pix_valid;
   assign io_vga.o_col         = r_col;
   assign io_vga.o_row         = r_row;
   assign io_vga.o_red         = r_red;
   assign io_vga.o_green       = r_green;
   assign io_vga.o_blue        = r_blue;
   assign io_vga.o_frame_start = r_frame_start;
   assign io_vga.o_locked      = r_locked;
   assign io_vga.o_err         = r_err;
   assign io_vga.o_err_cnt     = r_err_cnt;

`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
   localparam int unsigned KW = 16;

   logic [11:0]   w_rgb12;
   logic [KW-1:0] r_acc;
   logic [KW-1:0] r_checksum;
   logic          r_cks_valid;

   assign w_rgb12 = {io_vga.i_red, io_vga.i_green, io_vga.i_blue};

   // Frame checksum: restart on frame start, publish when the visible area has ended
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc       <= '0;
         r_checksum  <= '0;
         r_cks_valid <= 1'b0;
      end else begin
         if (w_fs_nxt) begin
            r_acc <= KW'(w_rgb12);
         end else if (w_pv_nxt) begin
            r_acc <= r_acc + KW'(w_rgb12);
         end
         r_cks_valid <= 1'b0;
         if (w_lock_nxt && (w_row_nxt == C_V_VIS) && (w_col_nxt == '0)) begin
            r_checksum  <= r_acc;
            r_cks_valid <= 1'b1;
         end
      end
   end

   assign io_vga.o_checksum  = r_checksum;
   assign io_vga.o_cks_valid = r_cks_valid;
`else
   assign io_vga.o_checksum  = '0;
   assign io_vga.o_cks_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down 32x20 timing
// (16+4+8+4 columns, 12+2+2+4 rows), active-low sync, LOCK_FRAMES = 2.
module tb_vga_sync_decoder;

   localparam int HV = 16, HF = 4, HS = 8, HB = 4;
   localparam int VV = 12, VF = 2, VS = 2, VB = 4;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FT = HT * VT;

   logic clk = 1'b0;
   logic rst = 1'b1;

   vga_sync_decoder_if vif ();

   vga_sync_decoder #(
      .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .io_vga (vif)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int n_errp   = 0;
   int hcnt = 0, vcnt = 0, fcnt = 0;
   int s_h = 0, s_v = 0, s_f = 0;
   int hs_lo = HV + HF;
   int hs_hi = HV + HF + HS - 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive the generator position, clock it in, sample outputs 1 time unit later
   task automatic tick();
      vif.i_hsync = !((hcnt >= hs_lo) && (hcnt <= hs_hi));
      vif.i_vsync = !((vcnt >= VV + VF) && (vcnt < VV + VF + VS));
      vif.i_red   = 4'(hcnt);
      vif.i_green = 4'(vcnt);
      vif.i_blue  = 4'(hcnt) ^ 4'(vcnt) ^ 4'h5;
      s_h = hcnt; s_v = vcnt; s_f = fcnt;
      @(posedge clk);
      #1;
      if (vif.o_err) n_errp++;
      hcnt++;
      if (hcnt == HT) begin
         hcnt = 0;
         vcnt++;
         if (vcnt == VT) begin
            vcnt = 0;
            fcnt++;
         end
      end
   endtask

   task automatic goto_pos(input int v, input int h);
      for (int k = 0; k < 2 * FT && !((vcnt == v) && (hcnt == h)); k++) tick();
      chk("goto_pos", 32'((vcnt == v) && (hcnt == h)), 32'd1);
   endtask

   task automatic wait_lock(input string tag);
      int found = 0;
      for (int k = 0; k < 4 * FT && found == 0; k++) begin
         tick();
         if (vif.o_locked) found = 1;
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_col"},    32'(vif.o_col), 32'd0);
      chk({tag, "_row"},    32'(vif.o_row), 32'd0);
      chk({tag, "_pv"},     32'(vif.o_pix_valid), 32'd0);
      chk({tag, "_rgb"},    32'({vif.o_red, vif.o_green, vif.o_blue}), 32'd0);
      chk({tag, "_fs"},     32'(vif.o_frame_start), 32'd0);
      chk({tag, "_locked"}, 32'(vif.o_locked), 32'd0);
      chk({tag, "_err"},    32'(vif.o_err), 32'd0);
      chk({tag, "_errcnt"}, 32'(vif.o_err_cnt), 32'd0);
      chk({tag, "_cks"},    32'(vif.o_checksum), 32'd0);
      chk({tag, "_cksv"},   32'(vif.o_cks_valid), 32'd0);
   endtask

   initial begin
      int early_lock, early_pv, errp0, inj_f;
      int bad_col, bad_row, bad_pv, bad_rgb, bad_fs, bad_lock, n_pv, n_fs, n_cks, bad_cks;
      logic        e_pv;
      logic [11:0] e_rgb;
      logic [15:0] m_acc;

      // Reset with idle (inactive) sync and non-zero colour on the inputs
      vif.i_hsync = 1'b1; vif.i_vsync = 1'b1;
      vif.i_red = 4'hF; vif.i_green = 4'hF; vif.i_blue = 4'hF;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;

      // Acquisition: H_OK at the first hsync, then three vsync edges (frames 0,1,2)
      early_lock = 0; early_pv = 0;
      for (int i = 0; i < 2 * FT + (VV + VF) * HT; i++) begin
         tick();
         if (s_f == 0 && s_v == 0 && s_h == HV + HF) chk("col_align", 32'(vif.o_col), 32'(HV + HF));
         if (vif.o_locked) early_lock++;
         if (vif.o_pix_valid) early_pv++;
      end
      chk("no_early_lock", 32'(early_lock), 32'd0);
      chk("no_pv_unlocked", 32'(early_pv), 32'd0);
      tick();
      chk("lock_rise", 32'(vif.o_locked), 32'd1);
      chk("lock_row", 32'(vif.o_row), 32'(VV + VF));
      chk("lock_col", 32'(vif.o_col), 32'd0);
      chk("acq_no_err", 32'(n_errp), 32'd0);

      // One full locked frame compared pixel by pixel against the generator
      bad_col = 0; bad_row = 0; bad_pv = 0; bad_rgb = 0; bad_fs = 0; bad_lock = 0;
      n_pv = 0; n_fs = 0; n_cks = 0; bad_cks = 0; m_acc = '0;
      for (int i = 0; i < FT; i++) begin
         tick();
         e_pv  = (s_v < VV) && (s_h < HV);
         e_rgb = e_pv ? {4'(s_h), 4'(s_v), 4'(s_h) ^ 4'(s_v) ^ 4'h5} : 12'h000;
         if (int'(vif.o_col) != s_h) bad_col++;
         if (int'(vif.o_row) != s_v) bad_row++;
         if (vif.o_pix_valid !== e_pv) bad_pv++;
         if ({vif.o_red, vif.o_green, vif.o_blue} !== e_rgb) bad_rgb++;
         if (vif.o_frame_start !== ((s_h == 0) && (s_v == 0))) bad_fs++;
         if (vif.o_locked !== 1'b1) bad_lock++;
         if (vif.o_pix_valid) n_pv++;
         if (vif.o_frame_start) n_fs++;
         if (vif.o_cks_valid) n_cks++;
`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
         if ((s_h == 0) && (s_v == 0)) m_acc = 16'(e_rgb);
         else if (e_pv) m_acc = m_acc + 16'(e_rgb);
         if ((s_v == VV) && (s_h == 0)) begin
            chk("cks_valid_pos", 32'(vif.o_cks_valid), 32'd1);
            chk("cks_value", 32'(vif.o_checksum), 32'(m_acc));
         end
`else
         if (vif.o_checksum !== 16'h0000) bad_cks++;
`endif
      end
      chk("frm_col", 32'(bad_col), 32'd0);
      chk("frm_row", 32'(bad_row), 32'd0);
      chk("frm_pv", 32'(bad_pv), 32'd0);
      chk("frm_rgb", 32'(bad_rgb), 32'd0);
      chk("frm_fs", 32'(bad_fs), 32'd0);
      chk("frm_locked", 32'(bad_lock), 32'd0);
      chk("frm_pv_count", 32'(n_pv), 32'(HV * VV));
      chk("frm_fs_count", 32'(n_fs), 32'd1);
`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
      chk("frm_cks_count", 32'(n_cks), 32'd1);
`else
      chk("frm_cks_count", 32'(n_cks), 32'd0);
      chk("frm_cks_zero", 32'(bad_cks), 32'd0);
`endif
      chk("frm_no_err", 32'(n_errp), 32'd0);

      // hsync asserted 3 clocks early on one line
      goto_pos(VV + VF + VS, 0);
      inj_f = fcnt;
      hs_lo = HV + HF - 3;
      for (int i = 0; i < HV + HF - 3; i++) tick();
      chk("early_no_err_before", 32'(n_errp), 32'd0);
      tick();
      chk("early_err", 32'(vif.o_err), 32'd1);
      chk("early_errcnt", 32'(vif.o_err_cnt), 32'd1);
      chk("early_unlock", 32'(vif.o_locked), 32'd0);
      chk("early_col", 32'(vif.o_col), 32'(HV + HF));
      tick();
      chk("early_err_pulse", 32'(vif.o_err), 32'd0);
      goto_pos(VV + VF + VS, HV + HF + HS);
      hs_lo = HV + HF;
      errp0 = n_errp;
      wait_lock("early_relock");
      chk("relock_frame", 32'(s_f), 32'(inj_f + 3));
      chk("relock_row", 32'(s_v), 32'(VV + VF));
      chk("relock_col", 32'(s_h), 32'd0);
      chk("relock_no_err", 32'(n_errp - errp0), 32'd0);
      chk("relock_errcnt", 32'(vif.o_err_cnt), 32'd1);

      // hsync held one clock too long: missing fall at the expected column
      goto_pos(3, 0);
      hs_hi = HV + HF + HS;
      errp0 = n_errp;
      for (int i = 0; i < HV + HF + HS; i++) tick();
      chk("long_no_err_before", 32'(n_errp - errp0), 32'd0);
      tick();
      chk("long_err", 32'(vif.o_err), 32'd1);
      chk("long_unlock", 32'(vif.o_locked), 32'd0);
      chk("long_errcnt", 32'(vif.o_err_cnt), 32'd2);
      tick();
      chk("long_err_pulse", 32'(vif.o_err), 32'd0);
      hs_hi = HV + HF + HS - 1;
      wait_lock("long_relock");

      // Reset mid-line while locked
      goto_pos(3, 0);
      for (int i = 0; i < 10; i++) tick();
      chk("pre_rst_locked", 32'(vif.o_locked), 32'd1);
      rst = 1'b1;
      tick();
      chk_all_zero("midrst");
      rst = 1'b0;
      early_lock = 0;
      errp0 = n_errp;
      for (int i = 0; i < FT; i++) begin
         tick();
         if (vif.o_locked) early_lock++;
      end
      chk("midrst_no_fast_lock", 32'(early_lock), 32'd0);
      chk("midrst_no_err", 32'(n_errp - errp0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
